// File: rtl/rsrx_01a_pkg.sv
// ---------------------------------------------------------------------------
// rsrx_01a_pkg
// Shared definitions for the 8N1 serial link: receiver state encodings and the
// default bit period, so the transmitter and receiver agree on the baud rate.
// Contents:
//   rx_state_t          - 2-bit receiver state encoding
//   RS_CLK_DIV_DEFAULT  - F25Clk cycles per bit for 115200 baud at 25 MHz
//   rs_cnt_width()      - width of a down-counter that must hold div-1
// ---------------------------------------------------------------------------
package rsrx_01a_pkg;

   // Fixed encodings so that any state dump or debug probe reads the same
   // numbers on both sides of the link.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } rx_state_t;

   // 25 MHz / 115200 baud, rounded to the nearest whole cycle.
   localparam int unsigned RS_CLK_DIV_DEFAULT = 217;

   // A counter that is loaded with div-1 and counts down to 0 needs
   // clog2(div) bits; never return less than one bit.
   function automatic int unsigned rs_cnt_width(input int unsigned div);
      int unsigned w;
      w = $clog2(div);
      if (w < 1) begin
         w = 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/rsrx_01a_sync2.sv
// ---------------------------------------------------------------------------
// sync2_01a
// Two-flop synchronizer for a single asynchronous input. Both flops reset to
// RESET_VAL so the synchronized output starts at the line's idle level.
// Ports:
//   clk    in   sampling clock
//   rst_n  in   asynchronous active-low reset
//   d      in   asynchronous input
//   q      out  synchronized copy of d, two clk cycles late
// ---------------------------------------------------------------------------
module sync2_01a #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   // The first flop may go metastable; the second gives it a full cycle to
   // settle before anything downstream looks at the value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/rsrx_01a.sv
// ---------------------------------------------------------------------------
// rsrx_01a
// 8N1 serial receiver. Synchronizes the RX pin, finds the falling start edge,
// samples each bit at its centre and presents the received byte with a
// one-cycle valid strobe, or a one-cycle framing-error strobe when the stop
// bit is low.
// Parameters:
//   CLK_DIV   F25Clk cycles per bit (4..4095)
//   HALF_DIV  cycles from start-edge detection to the start-bit mid-sample
// Ports:
//   F25Clk          in   system clock, rising edge
//   reset_n         in   asynchronous active-low reset
//   rxSerialData    in   serial line, idle high, asynchronous to F25Clk
//   rxParallelData  out  last correctly received byte
//   rxValid         out  one-cycle pulse when rxParallelData is updated
//   rxFrameErr      out  one-cycle pulse when the stop bit is sampled low
//   rxStatus        out  high while a frame is in progress
// ---------------------------------------------------------------------------
module rsrx_01a
   import rsrx_01a_pkg::*;
#(
   parameter int unsigned CLK_DIV  = RS_CLK_DIV_DEFAULT,
   parameter int unsigned HALF_DIV = CLK_DIV / 2
) (
   input  logic       F25Clk,
   input  logic       reset_n,
   input  logic       rxSerialData,
   output logic [7:0] rxParallelData,
   output logic       rxValid,
   output logic       rxFrameErr,
   output logic       rxStatus
);

   localparam int unsigned CW = rs_cnt_width(CLK_DIV);
   localparam logic [CW-1:0] RELOAD_FULL = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] RELOAD_HALF = CW'(HALF_DIV - 1);

   logic            rx_sync;
   logic            fall_edge;

   rx_state_t       state_q,   state_d;
   logic [CW-1:0]   cnt_q,     cnt_d;
   logic [2:0]      bit_idx_q, bit_idx_d;
   logic [7:0]      shreg_q,   shreg_d;
   logic [7:0]      data_q,    data_d;
   logic            valid_q,   valid_d;
   logic            err_q,     err_d;
   logic            status_q,  status_d;
   logic            rx_prev_q, rx_prev_d;
   logic [1:0]      flush_q,   flush_d;
   logic            armed_q,   armed_d;

   sync2_01a #(
      .RESET_VAL (1'b1)
   ) u_sync (
      .clk   (F25Clk),
      .rst_n (reset_n),
      .d     (rxSerialData),
      .q     (rx_sync)
   );

   // The synchronizer flops reset high, so if the pin is low when reset is
   // released the synchronized line would appear to fall. flush_q waits until
   // the synchronizer holds a real pin sample, and armed_q only opens the edge
   // detector once that real sample has been seen high.
   assign fall_edge = armed_q && rx_prev_q && !rx_sync;

   // Next-state logic for the whole receiver: the frame FSM, the bit timer,
   // the shift register and the registered output strobes.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      shreg_d   = shreg_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      err_d     = 1'b0;
      rx_prev_d = rx_sync;
      flush_d   = {flush_q[0], 1'b1};
      armed_d   = armed_q || (flush_q[1] && rx_sync);

      unique case (state_q)
         ST_IDLE: begin
            if (fall_edge) begin
               cnt_d   = RELOAD_HALF;
               state_d = ST_START;
            end
         end
         ST_START: begin
            // A line that is high again at mid-start was a glitch.
            if (cnt_q == '0) begin
               if (!rx_sync) begin
                  cnt_d     = RELOAD_FULL;
                  bit_idx_d = 3'd0;
                  state_d   = ST_DATA;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_DATA: begin
            // LSB arrives first, so shifting in at the MSB leaves bit 0 at
            // the bottom after eight samples.
            if (cnt_q == '0) begin
               shreg_d   = {rx_sync, shreg_q[7:1]};
               cnt_d     = RELOAD_FULL;
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
                  state_d = ST_STOP;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_STOP: begin
            // Leaving at mid-stop gives half a bit of slack to catch the
            // next start edge of a back-to-back frame.
            if (cnt_q == '0) begin
               if (rx_sync) begin
                  data_d  = shreg_q;
                  valid_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      status_d = (state_d != ST_IDLE);
   end

   // All receiver state and outputs update together; reset drops any partial
   // frame and returns every output to its idle value at once.
   always_ff @(posedge F25Clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         bit_idx_q <= 3'd0;
         shreg_q   <= 8'h00;
         data_q    <= 8'h00;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
         status_q  <= 1'b0;
         rx_prev_q <= 1'b1;
         flush_q   <= 2'b00;
         armed_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shreg_q   <= shreg_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
         status_q  <= status_d;
         rx_prev_q <= rx_prev_d;
         flush_q   <= flush_d;
         armed_q   <= armed_d;
      end
   end

   assign rxParallelData = data_q;
   assign rxValid        = valid_q;
   assign rxFrameErr     = err_q;
   assign rxStatus       = status_q;

endmodule

// File: tb/tb_rsrx_01a.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_rsrx_01a
// Self-checking bench for rsrx_01a at CLK_DIV = 16. A behavioural transmitter
// drives the serial line in real time; a reference model records which bytes
// and framing errors each frame must produce, and the monitor collects what
// the receiver actually reports.
// ---------------------------------------------------------------------------
module tb_rsrx_01a;

   localparam int unsigned DIV    = 16;
   localparam realtime     CLK_NS = 40.0;
   localparam realtime     BIT_NS = CLK_NS * DIV;

   logic       clk;
   logic       reset_n;
   logic       rx_line;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_err;
   logic       rx_status;

   int         checks;
   int         errors;
   int         cyc;
   int         n_err;
   int         exp_err;
   int         run;
   int         last_run;
   logic [7:0] got_q[$];
   logic [7:0] exp_q[$];
   int         valid_cyc[$];

   rsrx_01a #(
      .CLK_DIV (DIV)
   ) dut (
      .F25Clk         (clk),
      .reset_n        (reset_n),
      .rxSerialData   (rx_line),
      .rxParallelData (rx_data),
      .rxValid        (rx_valid),
      .rxFrameErr     (rx_err),
      .rxStatus       (rx_status)
   );

   // 25 MHz system clock.
   initial begin
      clk = 1'b0;
      forever #(CLK_NS / 2.0) clk = ~clk;
   end

   // One comparison: count it, and report tag/observed/expected if it fails.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Behavioural 8N1 transmitter: start bit, eight data bits LSB first, then
   // the given stop level, each held for bit_ns.
   task automatic applyStimulus(input logic [7:0] b, input logic stop, input realtime bit_ns);
      rx_line = 1'b0;
      #(bit_ns);
      for (int i = 0; i < 8; i++) begin
         rx_line = b[i];
         #(bit_ns);
      end
      rx_line = stop;
      #(bit_ns);
   endtask

   // The reference model: every frame with a high stop bit must deliver its
   // byte in order, and nothing else may be delivered.
   task automatic checkReceived(input string tag);
      int n;
      checkOutput({tag, "_count"}, got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         checkOutput({tag, "_data"}, {24'h0, got_q[i]}, {24'h0, exp_q[i]});
      end
      got_q.delete();
      exp_q.delete();
   endtask

   // Monitor sampled on the falling edge: collects delivered bytes with their
   // cycle stamps, counts framing errors and measures each rxStatus pulse.
   always @(negedge clk) begin
      cyc++;
      if (rx_valid) begin
         got_q.push_back(rx_data);
         valid_cyc.push_back(cyc);
      end
      if (rx_err) begin
         n_err++;
      end
      if (rx_valid || rx_err) begin
         checkOutput("valid_err_exclusive", {31'h0, rx_valid & rx_err}, 32'h0);
      end
      if (rx_status) begin
         run++;
      end else if (run != 0) begin
         last_run = run;
         run      = 0;
      end
   end

   // Directed sequence followed by a randomized loopback run.
   initial begin
      logic [7:0] b;
      logic [7:0] fr;
      realtime    bt;

      checks   = 0;
      errors   = 0;
      cyc      = 0;
      n_err    = 0;
      exp_err  = 0;
      run      = 0;
      last_run = 0;
      rx_line  = 1'b1;
      reset_n  = 1'b0;

      // Reset values.
      repeat (3) @(negedge clk);
      checkOutput("reset_data",   {24'h0, rx_data}, 32'h0);
      checkOutput("reset_valid",  {31'h0, rx_valid}, 32'h0);
      checkOutput("reset_err",    {31'h0, rx_err}, 32'h0);
      checkOutput("reset_status", {31'h0, rx_status}, 32'h0);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);

      // Single byte 0xA5; status spans HALF_DIV + 9*CLK_DIV cycles.
      $display("[TB] single byte 0xA5");
      applyStimulus(8'hA5, 1'b1, BIT_NS);
      exp_q.push_back(8'hA5);
      #(BIT_NS);
      checkReceived("a5");
      checkOutput("a5_data_out", {24'h0, rx_data}, 32'hA5);
      checkOutput("a5_frame_err", n_err, exp_err);
      checkOutput("a5_status_len", last_run, DIV / 2 + 9 * DIV);

      // Back-to-back frames, no idle gap.
      $display("[TB] back-to-back 0x00 0xFF 0x55");
      @(negedge clk);
      valid_cyc.delete();
      applyStimulus(8'h00, 1'b1, BIT_NS);
      applyStimulus(8'hFF, 1'b1, BIT_NS);
      applyStimulus(8'h55, 1'b1, BIT_NS);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'h55);
      #(2 * BIT_NS);
      checkReceived("b2b");
      checkOutput("b2b_stamps", valid_cyc.size(), 3);
      if (valid_cyc.size() >= 3) begin
         checkOutput("b2b_gap1", valid_cyc[1] - valid_cyc[0], 10 * DIV);
         checkOutput("b2b_gap2", valid_cyc[2] - valid_cyc[1], 10 * DIV);
      end

      // Three-cycle low glitch: aborts at mid-start.
      $display("[TB] glitch");
      @(negedge clk);
      rx_line = 1'b0;
      #(3 * CLK_NS);
      rx_line = 1'b1;
      #(2 * BIT_NS);
      checkReceived("glitch");
      checkOutput("glitch_frame_err", n_err, exp_err);
      checkOutput("glitch_status", {31'h0, rx_status}, 32'h0);
      checkOutput("glitch_status_len", last_run, DIV / 2);

      // Stop bit low, then line held low: one framing error only.
      $display("[TB] framing error 0x3C");
      applyStimulus(8'h3C, 1'b0, BIT_NS);
      exp_err++;
      #(4 * BIT_NS);
      checkReceived("ferr");
      checkOutput("ferr_count", n_err, exp_err);
      checkOutput("ferr_data_kept", {24'h0, rx_data}, 32'h55);
      checkOutput("ferr_status", {31'h0, rx_status}, 32'h0);
      rx_line = 1'b1;
      #(2 * BIT_NS);
      checkReceived("ferr_rise");
      checkOutput("ferr_rise_count", n_err, exp_err);

      // Reset during data bit 4 of 0xE7, released while the line is low.
      $display("[TB] reset mid-frame");
      fr = 8'hE7;
      rx_line = 1'b0;
      #(BIT_NS);
      for (int i = 0; i < 4; i++) begin
         rx_line = fr[i];
         #(BIT_NS);
      end
      rx_line = fr[4];
      #(BIT_NS / 2.0);
      reset_n = 1'b0;
      #1;
      checkOutput("rst_mid_data",   {24'h0, rx_data}, 32'h0);
      checkOutput("rst_mid_valid",  {31'h0, rx_valid}, 32'h0);
      checkOutput("rst_mid_err",    {31'h0, rx_err}, 32'h0);
      checkOutput("rst_mid_status", {31'h0, rx_status}, 32'h0);
      #(5 * CLK_NS);
      reset_n = 1'b1;
      #(3 * BIT_NS);
      checkReceived("rst_low");
      checkOutput("rst_low_status", {31'h0, rx_status}, 32'h0);
      checkOutput("rst_low_err", n_err, exp_err);
      rx_line = 1'b1;
      #(2 * BIT_NS);
      applyStimulus(8'h81, 1'b1, BIT_NS);
      exp_q.push_back(8'h81);
      #(BIT_NS);
      checkReceived("rst_81");
      checkOutput("rst_81_err", n_err, exp_err);

      // Loopback: 256 random bytes, transmitter 2% slow then 2% fast.
      $display("[TB] random loopback");
      for (int i = 0; i < 256; i++) begin
         b  = 8'($urandom);
         bt = (i < 128) ? BIT_NS * 1.02 : BIT_NS * 0.98;
         applyStimulus(b, 1'b1, bt);
         exp_q.push_back(b);
         if ($urandom_range(0, 1) == 1) begin
            #(bt);
         end
      end
      #(2 * BIT_NS);
      checkReceived("loop");
      checkOutput("loop_frame_err", n_err, exp_err);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rsrx_01a.md
# rsrx_01a

Asynchronous serial (UART-style) receiver, the receive-side counterpart of the team's 8N1 serial transmitter. It samples a single incoming serial line on the 25 MHz system clock, recovers 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit), and presents each byte on a parallel bus with a one-cycle valid strobe. It sits between the board-level RX pin and the command/debug logic, and runs entirely in the F25Clk domain.

## Interface
- CLK_DIV, 217, F25Clk cycles per bit (25 MHz / 115200); legal range 4..4095
- HALF_DIV, CLK_DIV/2, cycles from start-edge detection to the start-bit mid-sample
- F25Clk  input  1  system clock; all logic on the rising edge
- reset_n  input  1  one clock; reset is asynchronous and active-low
- rxSerialData  input  1  serial line, asynchronous to F25Clk, idle high
- rxParallelData  output  8  last correctly received byte; reset 8'h00
- rxValid  output  1  one-cycle pulse, rxParallelData newly updated; reset 0
- rxFrameErr  output  1  one-cycle pulse, stop bit sampled low; reset 0
- rxStatus  output  1  high while a frame is being received (state != IDLE); reset 0

## Operation
- Input passes through a 2-flop synchronizer; both flops reset to 1 (line idle). A third register holds the previous synchronized value for edge detection.
- States: IDLE, START, DATA, STOP.
- IDLE: on a falling edge of the synchronized line (prev = 1, now = 0), load the bit counter with HALF_DIV-1 and go to START. A line held low never retriggers; a new high-to-low transition is required.
- START: when the counter reaches 0, sample the line. If 0, reload CLK_DIV-1, clear the bit index, and go to DATA. If 1 (glitch or false start), return to IDLE with no output pulse.
- DATA: each time the counter reaches 0, shift the sample into the MSB of an 8-bit shift register (LSB arrives first), reload CLK_DIV-1, and increment the 3-bit index. After the 8th sample (index wraps 7->0), go to STOP.
- STOP: when the counter reaches 0, sample the line.
  - If 1: copy the shift register to rxParallelData and pulse rxValid.
  - If 0: pulse rxFrameErr; rxParallelData is unchanged.
  - Either way, return to IDLE at the mid-stop-bit point, which allows back-to-back frames.
- The counter is a down-counter of width clog2(CLK_DIV); it never wraps below 0 because it reloads on the cycle it reads 0.
- rxValid and rxFrameErr are mutually exclusive and never assert in the same cycle.

## Timing
- Synchronizer latency is 2 cycles; the edge is detected 3 cycles after the pin falls.
- Start mid-sample: HALF_DIV cycles after the edge detect. Each data/stop sample follows the previous one by exactly CLK_DIV cycles.
- rxValid / rxFrameErr assert the cycle after the stop sample register update (registered outputs). rxParallelData is valid in the same cycle as rxValid and holds until the next rxValid.
- rxStatus rises the cycle after the edge detect and falls in the same cycle rxValid/rxFrameErr rise.
- Asynchronous reset mid-frame: all outputs go immediately to their reset values and the state goes to IDLE; the partial frame is discarded. If the line is low when reset is released, no start is detected until it goes high and falls again.
- Baud tolerance: ±2% total mismatch must receive correctly at CLK_DIV ≥ 16.

## Structure
- Shared include rs_defs_01a.vh holds:
  - 2-bit state encodings (IDLE=0, START=1, DATA=2, STOP=3)
  - the default CLK_DIV for 115200 baud at 25 MHz, so the transmitter and receiver agree
- One natural sub-module: sync2_01a, a 2-flop synchronizer with a reset-value parameter (here 1). Everything else stays in rsrx_01a.

## Test plan
- Byte 8'hA5 sent at CLK_DIV=16 -> exactly one rxValid pulse, rxParallelData=8'hA5, rxFrameErr never high, rxStatus high for ~9.5 bit times.
- Back-to-back bytes 8'h00, 8'hFF, 8'h55 with no idle gap -> three rxValid pulses in order with matching data, spaced 10*CLK_DIV cycles apart.
- Low glitch of 3 cycles on an idle line -> START aborts at the mid-sample, no rxValid/rxFrameErr, rxStatus returns to 0.
- Frame 8'h3C with stop bit forced 0 -> one rxFrameErr pulse, no rxValid, rxParallelData keeps the previous value; line held low afterwards produces no further frames until it goes high and falls again.
- reset_n asserted during data bit 4 of a frame -> all outputs 0 / 8'h00 immediately; the next complete frame 8'h81 after release is received correctly.
- Transmitter loopback (same CLK_DIV): random 256 bytes, with the transmitter bit period shifted ±2% -> all bytes received and matched, no framing errors.
